burst_scheduler: RTL and testbench
==================================

# burst_scheduler

Arbitrates between a read requester and a write requester and turns each granted request into one DDR burst of `BL` beats. Beat addresses are generated with DDR sequential wrap inside the `BL`-aligned block. Sits upstream of the address incrementer and command issue logic, sequencing the per-beat address datapath. A programmable read/write turnaround gap is inserted whenever the bus direction changes.

## Interface
- `ADDR_W`, 16: beat address width.
- `BL`, 8: beats per burst; power of two, 2..16.
- `TURN_CYC`, 2: idle cycles inserted on a direction change; 0 disables the gap.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `rd_req`  in  1  read request; held until `rd_gnt`.
- `rd_addr`  in  ADDR_W  read start address; sampled in the `rd_gnt` cycle.
- `rd_gnt`  out  1  one-cycle read grant.
- `wr_req`  in  1  write request; held until `wr_gnt`.
- `wr_addr`  in  ADDR_W  write start address; sampled in the `wr_gnt` cycle.
- `wr_gnt`  out  1  one-cycle write grant.
- `beat_valid`  out  1  a beat is presented.
- `beat_ready`  in  1  downstream accepts the beat; a beat transfers when `beat_valid` and `beat_ready` are both high.
- `beat_addr`  out  ADDR_W  beat address.
- `beat_we`  out  1  1 = write burst, 0 = read burst.
- `beat_last`  out  1  final beat of the burst.
- `busy`  out  1  state is not IDLE.
- `stat_turns`  out  16  saturating count of turnarounds. Present only with `BURST_SCHED_STATS_EN`.

## Operation
- FSM states: IDLE, TURN, BURST.
- IDLE, arbitration:
  - If only one request is high, grant it.
  - If both are high, round-robin: grant the direction not granted last.
  - The round-robin pointer resets to favour read.
- IDLE, grant and next state:
  - `rd_gnt`/`wr_gnt` are combinational from IDLE, `req` and the arbiter choice.
  - In the grant cycle, capture `base = addr & ~(BL-1)`, `off = addr[log2(BL)-1:0]` and the direction.
  - Go to TURN if `TURN_CYC > 0`, a previous burst exists and the direction differs from it. Otherwise go to BURST.
- TURN:
  - The counter runs for `TURN_CYC` cycles with outputs idle, then the FSM goes to BURST.
- BURST, address generation:
  - `beat_addr = base | ((off + beat_cnt) mod BL)`.
  - Upper address bits never change; there is no carry out of the block.
  - `beat_cnt` increments only on a transfer.
  - `beat_last` is high when `beat_cnt == BL-1`.
- BURST, exit:
  - A transfer with `beat_last` high returns the FSM to IDLE.
  - It records the direction and sets the prev-valid flag.
- Backpressure:
  - While `beat_valid` is high and `beat_ready` is low, `beat_addr`, `beat_we` and `beat_last` hold stable.
  - `beat_valid` does not drop until the transfer completes.
- Requests arriving outside IDLE are ignored until IDLE. No grant is issued outside IDLE.

## Timing
- Reset values:
  - All outputs are 0 (`stat_turns` = 0).
  - State IDLE, `beat_cnt` 0, prev-valid flag cleared, pointer favours read.
- Grant latency: `gnt` is asserted in the same cycle as `req` when the FSM is in IDLE.
- First-beat latency:
  - `beat_valid` rises in the cycle after the grant when there is no turnaround.
  - With a turnaround, it rises `TURN_CYC + 1` cycles after the grant.
- Burst length: minimum `BL` cycles when `beat_ready` is held high.
- Gap between bursts: one idle IDLE cycle between the last beat of one burst and the first beat of the next same-direction burst.
- Reset mid-burst or mid-turn:
  - Outputs are 0 in the following cycle and the burst is abandoned.
  - The prev-valid flag is cleared, so the next burst never gets a turnaround.
- Reset has priority over a simultaneous grant or transfer.

## Configuration
- `BURST_SCHED_STATS_EN` defined:
  - Adds the `stat_turns` port and counter.
  - The counter increments once on each TURN entry and saturates at 0xFFFF.
  - It is cleared by `rst`.
- Not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
Parameters for all scenarios: `ADDR_W=16`, `BL=8`, `TURN_CYC=2`.
- Single read, `rd_addr=0x0105`, `beat_ready=1`:
  - `rd_gnt` is asserted for 1 cycle.
  - Beats are 0x0105, 0x0106, 0x0107, 0x0100, 0x0101, 0x0102, 0x0103, 0x0104.
  - `beat_last` is high only on 0x0104 and `beat_we=0`.
- `rd_req` and `wr_req` raised together after reset:
  - Read is granted first.
  - Write is granted in the IDLE cycle after the read's last beat.
  - 2 TURN cycles follow, then the write beats begin with `beat_we=1`.
- Backpressure: `beat_ready=0` for 3 cycles when the 3rd beat is presented (0x0107 for start 0x0105):
  - `beat_addr` holds 0x0107 and `beat_valid` stays high.
  - The burst completes in 11 cycles.
- Back-to-back writes at 0x0200 then 0x0208:
  - No TURN.
  - Exactly one idle cycle separates beat 0x0207 from beat 0x0208.
- Reset:
  - Assert `rst` during the 4th beat of a write; `beat_valid=0` and `busy=0` in the next cycle.
  - A subsequent read starts with no TURN gap.
- `BURST_SCHED_STATS_EN` defined, bursts R, W, R, W:
  - `stat_turns=3`.
  - Without the macro, the build has no `stat_turns` port and the beat sequences are identical.

Source files
------------

// File: rtl/burst_scheduler.sv
// burst_scheduler: read/write arbiter that expands each grant into one BL-beat DDR burst.
// Latency: grant is combinational in IDLE; first beat one cycle after grant, or TURN_CYC+1 on a direction change.
// Backpressure: beat_valid/ready; beat fields hold while stalled, requests wait in IDLE until granted.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   rd_req/rd_addr/rd_gnt  read requester (addr sampled in the grant cycle)
//   wr_req/wr_addr/wr_gnt  write requester (addr sampled in the grant cycle)
//   beat_valid/beat_ready  per-beat handshake; beat_addr/beat_we/beat_last describe the beat
//   busy                   FSM not in IDLE
//   stat_turns             saturating turnaround count, present only when BURST_SCHED_STATS_EN is defined
module burst_scheduler #(
  parameter int ADDR_W   = 16,
  parameter int BL       = 8,
  parameter int TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              beat_we,
  output logic              beat_last,
  output logic              busy
`ifdef BURST_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_turns
`endif
);

  localparam int LOG = $clog2(BL);
  localparam int TW  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BL - 1);
  localparam logic [LOG-1:0]    LAST_BEAT = LOG'(BL - 1);
  localparam logic [TW-1:0]     TURN_LAST = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, TURN, BURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LOG-1:0]    off_q, off_d;
  logic [LOG-1:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
  logic              we_q, we_d;
  logic              prev_vld_q, prev_vld_d;
  logic              prev_we_q, prev_we_d;
  // Round-robin pointer: 1 means a write wins when both request.
  logic              pref_wr_q, pref_wr_d;
  logic              grant_we;
  logic [ADDR_W-1:0] sel_addr;
  logic              turn_entry;
  // Offset arithmetic stays LOG bits wide so the wrap never carries into base.
  logic [LOG-1:0]    beat_off;

  assign beat_off = off_q + beat_cnt_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    off_d      = off_q;
    beat_cnt_d = beat_cnt_q;
    turn_cnt_d = turn_cnt_q;
    we_d       = we_q;
    prev_vld_d = prev_vld_q;
    prev_we_d  = prev_we_q;
    pref_wr_d  = pref_wr_q;
    grant_we   = 1'b0;
    sel_addr   = '0;
    turn_entry = 1'b0;
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          grant_we   = wr_req && (!rd_req || pref_wr_q);
          rd_gnt     = !grant_we;
          wr_gnt     = grant_we;
          sel_addr   = grant_we ? wr_addr : rd_addr;
          base_d     = sel_addr & ~OFF_MASK;
          off_d      = sel_addr[LOG-1:0];
          we_d       = grant_we;
          pref_wr_d  = !grant_we;
          beat_cnt_d = '0;
          turn_cnt_d = '0;
          if ((TURN_CYC > 0) && prev_vld_q && (prev_we_q != grant_we)) begin
            state_d    = TURN;
            turn_entry = 1'b1;
          end else begin
            state_d = BURST;
          end
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d = BURST;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      BURST: begin
        if (beat_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = IDLE;
            prev_vld_d = 1'b1;
            prev_we_d  = we_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      off_q      <= '0;
      beat_cnt_q <= '0;
      turn_cnt_q <= '0;
      we_q       <= 1'b0;
      prev_vld_q <= 1'b0;
      prev_we_q  <= 1'b0;
      pref_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      off_q      <= off_d;
      beat_cnt_q <= beat_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      we_q       <= we_d;
      prev_vld_q <= prev_vld_d;
      prev_we_q  <= prev_we_d;
      pref_wr_q  <= pref_wr_d;
    end
  end

  assign beat_valid = (state_q == BURST);
  assign beat_addr  = beat_valid ? (base_q | {{(ADDR_W-LOG){1'b0}}, beat_off}) : '0;
  assign beat_we    = beat_valid && we_q;
  assign beat_last  = beat_valid && (beat_cnt_q == LAST_BEAT);
  assign busy       = (state_q != IDLE);

`ifdef BURST_SCHED_STATS_EN
  logic [15:0] stat_turns_q, stat_turns_d;

  always_comb begin
    stat_turns_d = stat_turns_q;
    if (turn_entry && (stat_turns_q != 16'hFFFF)) begin
      stat_turns_d = stat_turns_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_turns_q <= '0;
    end else begin
      stat_turns_q <= stat_turns_d;
    end
  end

  assign stat_turns = stat_turns_q;
`endif

endmodule

// File: tb/tb_burst_scheduler.sv
module tb_burst_scheduler;
  localparam int AW = 16;
  localparam int BL = 8;
  localparam int TC = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic          last;
    logic          first;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_gnt;
  logic          beat_valid;
  logic          beat_ready = 1'b1;
  logic [AW-1:0] beat_addr;
  logic          beat_we;
  logic          beat_last;
  logic          busy;
`ifdef BURST_SCHED_STATS_EN
  logic [15:0]   stat_turns;
`endif

  burst_scheduler #(.ADDR_W(AW), .BL(BL), .TURN_CYC(TC)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_addr(beat_addr), .beat_we(beat_we), .beat_last(beat_last),
    .busy(busy)
`ifdef BURST_SCHED_STATS_EN
    , .stat_turns(stat_turns)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;
  beat_t sb[$];
  int first_cyc = -1;
  int last_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no response within bound, expected one (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the expected beat on every transfer and checks stall stability.
  logic        stall_prev = 1'b0;
  logic [17:0] stall_dat = '0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(beat_valid), 32'd1);
        check("hold_beat", 32'({beat_addr, beat_we, beat_last}), 32'(stall_dat));
      end
      if (beat_valid && beat_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", beat_addr);
        end else begin
          e = sb.pop_front();
          check("beat", 32'({beat_addr, beat_we, beat_last}), 32'({e.addr, e.we, e.last}));
          if (e.first) first_cyc = cyc;
          if (e.last) last_cyc = cyc;
        end
      end
      stall_prev = beat_valid && !beat_ready;
      stall_dat  = {beat_addr, beat_we, beat_last};
    end
  end

  task automatic push_burst(input logic we, input logic [AW-1:0] addr);
    logic [AW-1:0] base;
    logic [2:0] off;
    beat_t e;
    base = addr & 16'hFFF8;
    for (int i = 0; i < BL; i++) begin
      off = addr[2:0] + 3'(i);
      e.addr = base | {13'd0, off};
      e.we = we;
      e.last = (i == BL - 1);
      e.first = (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_gnt(input logic we, output int gc);
    gc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (we ? wr_gnt : rd_gnt) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) fail_to(we ? "wr_gnt" : "rd_gnt");
    else check(we ? "rd_gnt_excl" : "wr_gnt_excl", 32'(we ? rd_gnt : wr_gnt), 32'd0);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, output int gc);
    @(posedge clk); #1;
    if (we) begin wr_req = 1'b1; wr_addr = addr; end
    else begin rd_req = 1'b1; rd_addr = addr; end
    wait_gnt(we, gc);
    if (gc >= 0) push_burst(we, addr);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_to(name);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (beat_valid && beat_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_to(name);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, gc2, lc1;
    logic [AW-1:0] t1 [BL];
    beat_t e;
    t1 = '{16'h0105, 16'h0106, 16'h0107, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({rd_gnt, wr_gnt, beat_valid, beat_we, beat_last, busy}), 32'd0);
    check("rst_addr", 32'(beat_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'({rd_gnt, wr_gnt, beat_valid, beat_we, beat_last, busy}), 32'd0);
`ifdef BURST_SCHED_STATS_EN
    check("rst_stat_turns", 32'(stat_turns), 32'd0);
`endif

    // Single read at 0x0105, explicit beat table
    @(posedge clk); #1;
    rd_req = 1'b1;
    rd_addr = 16'h0105;
    wait_gnt(1'b0, gc);
    for (int i = 0; i < BL; i++) begin
      e.addr = t1[i]; e.we = 1'b0; e.last = (i == BL - 1); e.first = (i == 0);
      sb.push_back(e);
    end
    @(negedge clk);
    check("rd_gnt_one_cycle", 32'(rd_gnt), 32'd0);
    rd_req = 1'b0;
    wait_done("t1_done");
    check("t1_first_latency", 32'(first_cyc - gc), 32'd1);
    check("t1_burst_len", 32'(last_cyc - first_cyc + 1), 32'(BL));

    // Simultaneous requests after reset: read first, then write after a turnaround
    pulse_reset();
    rd_req = 1'b1; rd_addr = 16'h0010;
    wr_req = 1'b1; wr_addr = 16'h0020;
    wait_gnt(1'b0, gc);
    push_burst(1'b0, 16'h0010);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_gnt(1'b1, gc2);
    check("t2_wr_gnt_after_last", 32'(gc2 - last_cyc), 32'd1);
    push_burst(1'b1, 16'h0020);
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    check("t2_turn1", 32'({busy, beat_valid}), 32'b10);
    @(negedge clk);
    check("t2_turn2", 32'({busy, beat_valid}), 32'b10);
    wait_done("t2_done");
    check("t2_turn_latency", 32'(first_cyc - gc2), 32'(TC + 1));

    // Backpressure: 3 stalled cycles on the beat at 0x0107
    issue(1'b0, 16'h0105, gc);
    wait_addr(16'h0106, "t3_find_0106");
    @(posedge clk); #1;
    beat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    beat_ready = 1'b1;
    wait_done("t3_done");
    check("t3_stalled_len", 32'(last_cyc - first_cyc + 1), 32'd11);

    // Back-to-back writes 0x0200 then 0x0208
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 16'h0200;
    wait_gnt(1'b1, gc);
    push_burst(1'b1, 16'h0200);
    @(posedge clk); #1;
    wr_addr = 16'h0208;
    wait_gnt(1'b1, gc2);
    lc1 = last_cyc;
    push_burst(1'b1, 16'h0208);
    @(posedge clk); #1;
    wr_req = 1'b0;
    check("t4_gnt_gap", 32'(gc2 - lc1), 32'd1);
    wait_done("t4_done");
    check("t4_no_turn", 32'(first_cyc - gc2), 32'd1);
    check("t4_idle_gap", 32'(first_cyc - lc1), 32'd2);

    // Reset during the 4th beat of a write
    issue(1'b1, 16'h0300, gc);
    wait_addr(16'h0302, "t5_find_0302");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t5_after_rst", 32'({beat_valid, busy}), 32'd0);
    issue(1'b0, 16'h0400, gc);
    wait_done("t5_done");
    check("t5_no_turn", 32'(first_cyc - gc), 32'd1);

`ifdef BURST_SCHED_STATS_EN
    pulse_reset();
    @(negedge clk);
    check("t6_stat_cleared", 32'(stat_turns), 32'd0);
    issue(1'b0, 16'h0500, gc); wait_done("t6_r1");
    issue(1'b1, 16'h0510, gc); wait_done("t6_w1");
    issue(1'b0, 16'h0520, gc); wait_done("t6_r2");
    issue(1'b1, 16'h0530, gc); wait_done("t6_w2");
    check("t6_stat_turns", 32'(stat_turns), 32'd3);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
